param_sequence_detector: RTL and testbench

Parametrised serial bit-pattern detector. It is the general-purpose successor to the fixed-pattern detector FSMs in the basic-examples set. The pattern, don't-care mask and overlap mode are run-time inputs, the pattern width is a parameter, and a saturating match counter is included. It sits directly on a 1-bit serial stream qualified by a valid strobe.

---
 rtl/psd_pkg.sv | 18 +
 rtl/psd_window.sv | 70 +++++++
 rtl/param_sequence_detector.sv | 95 +++++++++
 tb/tb_param_sequence_detector.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/psd_pkg.sv
// rtl/psd_pkg.sv - shared types and helpers for the parametrised sequence detector
//
// Purpose: state encoding and fill-counter sizing shared by psd_window and
// param_sequence_detector.
package psd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  // Fill counts 0..width inclusive, so it needs one more code than width.
  function automatic int fill_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/psd_window.sv
// rtl/psd_window.sv - shift history, fill counter and masked compare
//
// Purpose: holds the last WIDTH accepted bits and how many of them are valid,
// and flags a match against the post-shift window for the bit being accepted.
// Ports:
//   clk, reset        clock, async active-low reset
//   clear             synchronous clear of history and fill
//   accept            a bit is being taken this cycle
//   data_in           serial bit
//   pattern           target; pattern[WIDTH-1] is the earliest bit
//   pattern_mask      1 = compare this position
//   overlap           0 = restart the window after a match
//   match             combinational: the accepted bit completes a match
//   full_next         window will be full after this edge
module psd_window
  import psd_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             accept,
  input  logic             data_in,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] pattern_mask,
  input  logic             overlap,
  output logic             match,
  output logic             full_next
);

  localparam int FW = fill_width(WIDTH);
  localparam logic [FW-1:0] FULL = FW'(WIDTH);

  logic [WIDTH-1:0] history;
  logic [WIDTH-1:0] history_next;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_inc;
  logic             restart;

  always_comb begin
    history_next = {history[WIDTH-2:0], data_in};
    fill_inc     = (fill == FULL) ? fill : fill + 1'b1;
    match        = accept && (fill_inc == FULL) &&
                   (((history_next ^ pattern) & pattern_mask) == '0);
    restart      = match && !overlap;
    if (clear) begin
      full_next = 1'b0;
    end else if (accept) begin
      full_next = !restart && (fill_inc == FULL);
    end else begin
      full_next = (fill == FULL);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (accept) begin
      history <= history_next;
      // Non-overlap mode: the matching bit is consumed, WIDTH fresh bits follow.
      fill    <= restart ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/param_sequence_detector.sv
// rtl/param_sequence_detector.sv - parametrised serial bit-pattern detector
//
// Purpose: detects a run-time pattern (with don't-care mask) on a valid-qualified
// serial stream, pulses detected once per match and counts matches (saturating).
// Ports:
//   clk, reset        clock, async active-low reset
//   enable            0 = ignore bits, FSM holds in IDLE
//   clear             synchronous clear of history, fill, count, detected
//   data_valid        qualifies data_in
//   data_in           serial bit
//   pattern           target; pattern[WIDTH-1] is the earliest bit
//   pattern_mask      1 = compare, 0 = don't care
//   overlap           1 = overlapping matches allowed
//   detected          one-cycle registered match pulse
//   match_count       saturating match counter
//   busy              1 in FILL or HUNT
module param_sequence_detector
  import psd_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             data_valid,
  input  logic             data_in,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] pattern_mask,
  input  logic             overlap,
  output logic             detected,
  output logic [CNT_W-1:0] match_count,
  output logic             busy
);

  state_t state;
  logic   accept;
  logic   match;
  logic   full_next;
  logic   match_pend;

  assign accept = enable && data_valid && !clear;

  psd_window #(
    .WIDTH(WIDTH)
  ) u_window (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .accept      (accept),
    .data_in     (data_in),
    .pattern     (pattern),
    .pattern_mask(pattern_mask),
    .overlap     (overlap),
    .match       (match),
    .full_next   (full_next)
  );

  assign busy = (state == FILL) || (state == HUNT);

  // The compare uses the pattern present when the bit is accepted; the result
  // is held one cycle in match_pend so detected rises one edge after acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      match_pend  <= 1'b0;
      detected    <= 1'b0;
      match_count <= '0;
    end else if (clear) begin
      state       <= enable ? FILL : IDLE;
      match_pend  <= 1'b0;
      detected    <= 1'b0;
      match_count <= '0;
    end else begin
      match_pend <= match;
      detected   <= match_pend;
      if (match_pend && (match_count != '1)) begin
        match_count <= match_count + 1'b1;
      end
      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    state <= full_next ? HUNT : FILL;
          FILL:    if (full_next) state <= HUNT;
          // Leaving a full window only happens on a non-overlap restart.
          HUNT:    if (!full_next) state <= FILL;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_param_sequence_detector.sv
// tb/tb_param_sequence_detector.sv - self-checking bench for param_sequence_detector
module tb_param_sequence_detector;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             clear;
  logic             data_valid;
  logic             data_in;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] pattern_mask;
  logic             overlap;
  logic             detected;
  logic [CNT_W-1:0] match_count;
  logic             busy;

  always #5 clk = ~clk;

  param_sequence_detector #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .pattern     (pattern),
    .pattern_mask(pattern_mask),
    .overlap     (overlap),
    .detected    (detected),
    .match_count (match_count),
    .busy        (busy)
  );

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  // Expected detected value at each future sampling point (two steps ahead).
  logic exp_q[$];
  logic [WIDTH-1:0] m_hist;
  int m_fill;
  int m_cnt;
  logic m_busy;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: check outputs against the scoreboard, drive one cycle.
  task automatic step(input logic e, input logic c, input logic v, input logic d);
    logic exp_det;
    logic hit;
    exp_det = exp_q.pop_front();
    check_bit("detected", detected, exp_det);
    if (detected === 1'b1) pulses++;
    if (exp_det && m_cnt < CNT_MAX) m_cnt++;
    check_val("match_count", 32'(match_count), 32'(m_cnt));
    check_bit("busy", busy, m_busy);
    enable = e;
    clear = c;
    data_valid = v;
    data_in = d;
    hit = 1'b0;
    if (c) begin
      m_hist = '0;
      m_fill = 0;
      m_cnt = 0;
      exp_q[exp_q.size()-1] = 1'b0;
    end else if (e && v) begin
      m_hist = {m_hist[WIDTH-2:0], d};
      if (m_fill < WIDTH) m_fill++;
      hit = (m_fill == WIDTH) && (((m_hist ^ pattern) & pattern_mask) == '0);
      if (hit && !overlap) m_fill = 0;
    end
    m_busy = e;
    exp_q.push_back(hit);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input int max_gap);
    for (int i = n - 1; i >= 0; i--) begin
      repeat ($urandom_range(0, max_gap)) step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      step(1'b1, 1'b0, 1'b1, bits[i]);
    end
  endtask

  task automatic flush();
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    pulses = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_bit("rst_detected", detected, 1'b0);
    check_val("rst_match_count", 32'(match_count), 32'd0);
    check_bit("rst_busy", busy, 1'b0);
    m_hist = '0;
    m_fill = 0;
    m_cnt = 0;
    m_busy = 1'b0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    pulses = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    clear = 1'b0;
    data_valid = 1'b0;
    data_in = 1'b0;
    pattern = 4'b1011;
    pattern_mask = 4'b1111;
    overlap = 1'b1;
    @(negedge clk);
    do_reset();

    // 1: overlapping matches after bits 4 and 7
    do_clear();
    send_bits(32'b1011011, 7, 0);
    flush();
    check_val("s1_count", 32'(match_count), 32'd2);
    check_val("s1_pulses", 32'(pulses), 32'd2);

    // 2: non-overlap, matches after bits 4 and 11 only
    overlap = 1'b0;
    do_clear();
    send_bits(32'b10110111011, 11, 0);
    flush();
    check_val("s2_count", 32'(match_count), 32'd2);
    check_val("s2_pulses", 32'(pulses), 32'd2);

    // 3: valid gaps, then masked pattern 1xx1
    overlap = 1'b1;
    do_clear();
    send_bits(32'b1011011, 7, 2);
    flush();
    check_val("s3a_count", 32'(match_count), 32'd2);
    pattern = 4'b1001;
    pattern_mask = 4'b1001;
    do_clear();
    send_bits(32'b1001111, 7, 0);
    flush();
    check_val("s3b_count", 32'(match_count), 32'd2);
    check_val("s3b_pulses", 32'(pulses), 32'd2);

    // 4: saturation of a 2-bit counter
    pattern = 4'b1111;
    pattern_mask = 4'b1111;
    do_clear();
    send_bits(32'b11111111, 8, 0);
    flush();
    check_val("s4_count", 32'(match_count), 32'd3);
    check_val("s4_pulses", 32'(pulses), 32'd5);

    // 5a: reset mid-stream, then 1 + 1011 matches once at the end
    pattern = 4'b1011;
    do_clear();
    send_bits(32'b101, 3, 0);
    do_reset();
    send_bits(32'b11011, 5, 0);
    flush();
    check_val("s5a_count", 32'(match_count), 32'd1);
    check_val("s5a_pulses", 32'(pulses), 32'd1);

    // 5b: clear on the completing bit drops it
    do_clear();
    send_bits(32'b101, 3, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    flush();
    check_val("s5b_count", 32'(match_count), 32'd0);
    check_val("s5b_pulses", 32'(pulses), 32'd0);
    check_bit("s5b_busy", busy, 1'b1);

    // 6: disabled junk is ignored, history retained across the gap
    do_clear();
    send_bits(32'b10, 2, 0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
    check_bit("s6_busy_disabled", busy, 1'b0);
    send_bits(32'b11, 2, 0);
    flush();
    check_val("s6_count", 32'(match_count), 32'd1);
    check_val("s6_pulses", 32'(pulses), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
